bus_arbiter_2to1: RTL and testbench



---
 rtl/bus_arbiter_2to1_pkg.sv | 19 +
 rtl/bus_arbiter_2to1_word_sel_mux.sv | 18 +
 rtl/bus_arbiter_2to1.sv | 160 ++++++++++++++++
 tb/tb_bus_arbiter_2to1.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_2to1_pkg.sv
// Shared encodings for the two-requester round-robin word arbiter.
// The FSM states double as grant owners; SRC_* tag output words by origin.
package bus_arbiter_2to1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2
  } state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // The requester that gets the next tie once the current one is released.
  function automatic logic other_src(input logic src);
    return ~src;
  endfunction

endpackage

// File: rtl/bus_arbiter_2to1_word_sel_mux.sv
// Combinational 2:1 select of the two requesters' word and last flag.
// sel_i follows the registered grant, so the path is mux -> output register.
module word_sel_mux #(
  parameter int WIDTH = 32
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] a_data_i,
  input  logic             a_last_i,
  input  logic [WIDTH-1:0] b_data_i,
  input  logic             b_last_i,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);

  assign data_o = sel_i ? b_data_i : a_data_i;
  assign last_o = sel_i ? b_last_i : a_last_i;

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Round-robin arbiter for two word producers sharing one consumer port.
// Grants last a whole burst (last flag) or MAX_BURST words, whichever is first.
module bus_arbiter_2to1
  import bus_arbiter_2to1_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  state_e             state_q, state_d;
  logic               prio_q, prio_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sel_q, sel_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               out_src_q, out_src_d;

  logic [WIDTH-1:0]   mux_data;
  logic               mux_last;
  logic               out_free;
  logic               granted_valid;
  logic               accept;
  logic [CNT_W-1:0]   cnt_inc;
  logic               grant_end;
  logic               other_valid;

  word_sel_mux #(.WIDTH(WIDTH)) u_word_sel_mux (
    .sel_i    (sel_q),
    .a_data_i (a_data),
    .a_last_i (a_last),
    .b_data_i (b_data),
    .b_last_i (b_last),
    .data_o   (mux_data),
    .last_o   (mux_last)
  );

  // The output slot can take a word when empty or being drained this cycle.
  assign out_free      = !out_valid_q || out_ready;
  assign a_ready       = (state_q == ST_GRANT_A) && out_free;
  assign b_ready       = (state_q == ST_GRANT_B) && out_free;
  assign granted_valid = ((state_q == ST_GRANT_A) && a_valid) ||
                         ((state_q == ST_GRANT_B) && b_valid);
  assign accept        = granted_valid && out_free;
  assign cnt_inc       = cnt_q + CNT_W'(1);
  assign grant_end     = accept && (mux_last || (cnt_inc == CNT_MAX));
  assign other_valid   = (sel_q == SRC_A) ? b_valid : a_valid;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (a_valid && (!b_valid || (prio_q == SRC_A))) begin
          state_d = ST_GRANT_A;
          cnt_d   = '0;
        end else if (b_valid) begin
          state_d = ST_GRANT_B;
          cnt_d   = '0;
        end
      end
      ST_GRANT_A, ST_GRANT_B: begin
        if (accept) begin
          cnt_d = cnt_inc;
        end
        if (grant_end) begin
          prio_d = other_src(sel_q);
          cnt_d  = '0;
          // Hand over without an IDLE bubble when the other side is waiting.
          if (other_valid) begin
            state_d = (sel_q == SRC_A) ? ST_GRANT_B : ST_GRANT_A;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_d = sel_q;
    if (state_d == ST_GRANT_B) begin
      sel_d = SRC_B;
    end else if (state_d == ST_GRANT_A) begin
      sel_d = SRC_A;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_last_d  = mux_last;
      out_src_d   = sel_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      prio_q      <= SRC_A;
      cnt_q       <= '0;
      sel_q       <= SRC_A;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= SRC_A;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign sel       = sel_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Self-checking bench for bus_arbiter_2to1 (MAX_BURST = 4): directed bursts
// plus random traffic against a grant-ownership model and per-source scoreboard.
module tb_bus_arbiter_2to1;

  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             a_valid, a_last, a_ready;
  logic             b_valid, b_last, b_ready;
  logic [WIDTH-1:0] a_data, b_data, out_data;
  logic             out_valid, out_last, out_src, out_ready, sel, busy;

  always #5 clk = ~clk;

  bus_arbiter_2to1 #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_last    (a_last),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_last    (b_last),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake (cycle %0d)", name, cyc);
  endtask

  // Model: who owns the grant (-1 none, 0 A, 1 B), who wins the next tie,
  // words taken in this grant, and the contents of the one-word output slot.
  int               m_owner, m_prio, m_cnt;
  logic             m_ov, m_ol, m_os, m_sel;
  logic [WIDTH-1:0] m_od;
  logic             acc [2];
  logic [WIDTH:0]   sb_a [$];
  logic [WIDTH:0]   sb_b [$];

  bit               cap_en = 1'b0;
  logic [WIDTH-1:0] cap_data [$];
  logic             cap_last [$];
  logic             cap_src  [$];
  int               cap_cyc  [$];

  function automatic void model_reset();
    m_owner = -1;
    m_prio  = 0;
    m_cnt   = 0;
    m_ov    = 1'b0;
    m_od    = '0;
    m_ol    = 1'b0;
    m_os    = 1'b0;
    m_sel   = 1'b0;
    acc[0]  = 1'b0;
    acc[1]  = 1'b0;
    sb_a.delete();
    sb_b.delete();
  endfunction

  always @(negedge clk) begin : compare
    logic             v [2];
    logic             l [2];
    logic             rdy [2];
    logic [WIDTH-1:0] d [2];
    logic             open;
    logic [WIDTH:0]   w;
    int               srv;
    bit               done;

    cyc++;
    v[0] = a_valid; d[0] = a_data; l[0] = a_last;
    v[1] = b_valid; d[1] = b_data; l[1] = b_last;
    if (reset) model_reset();

    open   = !m_ov || out_ready;
    rdy[0] = (m_owner == 0) && open;
    rdy[1] = (m_owner == 1) && open;

    check("out_valid", out_valid, m_ov);
    check("out_data",  out_data,  m_od);
    check("out_last",  out_last,  m_ol);
    check("out_src",   out_src,   m_os);
    check("sel",       sel,       m_sel);
    check("busy",      busy,      m_owner >= 0);
    check("a_ready",   a_ready,   rdy[0]);
    check("b_ready",   b_ready,   rdy[1]);

    if (!reset && out_valid && out_ready) begin
      if ((out_src ? sb_b.size() : sb_a.size()) == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_word actual=unexpected word %0h required=none (cycle %0d)", out_data, cyc);
      end else begin
        w = out_src ? sb_b.pop_front() : sb_a.pop_front();
        check("sb_word", {out_last, out_data}, w);
      end
      if (cap_en) begin
        cap_data.push_back(out_data);
        cap_last.push_back(out_last);
        cap_src.push_back(out_src);
        cap_cyc.push_back(cyc);
      end
    end

    acc[0] = !reset && v[0] && rdy[0];
    acc[1] = !reset && v[1] && rdy[1];

    if (!reset) begin
      srv  = -1;
      done = 1'b0;
      if (acc[0]) srv = 0;
      if (acc[1]) srv = 1;
      if (srv >= 0) begin
        m_ov = 1'b1;
        m_od = d[srv];
        m_ol = l[srv];
        m_os = srv[0];
        m_cnt++;
        done = l[srv] || (m_cnt == MAX_BURST);
        if (srv == 0) sb_a.push_back({l[0], d[0]});
        else          sb_b.push_back({l[1], d[1]});
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (m_owner < 0) begin
        if (v[0] && (!v[1] || m_prio == 0)) begin
          m_owner = 0; m_cnt = 0;
        end else if (v[1]) begin
          m_owner = 1; m_cnt = 0;
        end
      end else if (done) begin
        m_prio = 1 - srv;
        if (v[1 - srv]) begin
          m_owner = 1 - srv; m_cnt = 0;
        end else begin
          m_owner = -1;
        end
      end
      if (m_owner >= 0) m_sel = m_owner[0];
    end
  end

  task automatic drive_req(input int r, input logic v, input logic [WIDTH-1:0] dd, input logic ll);
    if (r == 0) begin
      a_valid = v; a_data = dd; a_last = ll;
    end else begin
      b_valid = v; b_data = dd; b_last = ll;
    end
  endtask

  task automatic send_word(input int r, input logic [WIDTH-1:0] dd, input logic ll);
    bit ok = 1'b0;
    drive_req(r, 1'b1, dd, ll);
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = (r == 0) ? a_ready : b_ready;
    end
    if (!ok) timeout_fail(r == 0 ? "send_a" : "send_b");
    @(posedge clk);
    #1;
    drive_req(r, 1'b0, dd, 1'b0);
  endtask

  task automatic send_burst(input int r, input logic [WIDTH-1:0] base, input int len);
    for (int i = 0; i < len; i++) send_word(r, base + WIDTH'(i), i == len - 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive_req(0, 1'b0, '0, 1'b0);
    drive_req(1, 1'b0, '0, 1'b0);
    out_ready = 1'b1;
    idle_cycles(2);
    reset = 1'b0;
  endtask

  task automatic start_capture();
    cap_data.delete(); cap_last.delete(); cap_src.delete(); cap_cyc.delete();
    cap_en = 1'b1;
  endtask

  logic [WIDTH-1:0] rd [2];
  logic             rl [2];
  int               fr_src  [12] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
  int               fr_last [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
  logic [WIDTH-1:0] fr_data [12] = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hD0, 32'hD1,
                                     32'hC4, 32'hC5, 32'hC6, 32'hC7, 32'hC8, 32'hC9};

  initial begin
    // Reset held with every input active: nothing may leak through.
    reset = 1'b1;
    drive_req(0, 1'b1, 32'hAAAA_0001, 1'b1);
    drive_req(1, 1'b1, 32'hBBBB_0001, 1'b1);
    out_ready = 1'b1;
    idle_cycles(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_sel", sel, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    #1;
    check("pre_grant_busy", busy, 0);
    idle_cycles(1);
    check("first_grant_busy", busy, 1);
    check("first_grant_a_ready", a_ready, 1);
    check("first_grant_sel", sel, 0);

    // A-only three-word burst.
    apply_reset();
    start_capture();
    send_word(0, 32'h11, 1'b0);
    send_word(0, 32'h22, 1'b0);
    send_word(0, 32'h33, 1'b1);
    idle_cycles(3);
    cap_en = 1'b0;
    check("a3_count", cap_data.size(), 3);
    if (cap_data.size() == 3) begin
      check("a3_d0", cap_data[0], 32'h11);
      check("a3_d1", cap_data[1], 32'h22);
      check("a3_d2", cap_data[2], 32'h33);
      check("a3_last", {cap_last[0], cap_last[1], cap_last[2]}, 3'b001);
      check("a3_src", {cap_src[0], cap_src[1], cap_src[2]}, 3'b000);
      check("a3_gap", cap_cyc[2] - cap_cyc[0], 2);
    end
    check("a3_idle", busy, 0);

    // Simultaneous 2-word bursts: A first, then B.
    apply_reset();
    start_capture();
    fork
      send_burst(0, 32'hA0, 2);
      send_burst(1, 32'hB0, 2);
    join
    idle_cycles(3);
    cap_en = 1'b0;
    check("tie_count", cap_data.size(), 4);
    if (cap_data.size() == 4) begin
      check("tie_src", {cap_src[0], cap_src[1], cap_src[2], cap_src[3]}, 4'b0011);
      check("tie_d0", cap_data[0], 32'hA0);
      check("tie_d3", cap_data[3], 32'hB1);
    end

    // Forced release every MAX_BURST words with B waiting once.
    apply_reset();
    start_capture();
    fork
      send_burst(0, 32'hC0, 10);
      send_burst(1, 32'hD0, 2);
    join
    idle_cycles(3);
    cap_en = 1'b0;
    check("frc_count", cap_data.size(), 12);
    if (cap_data.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        check("frc_src",  cap_src[i],  fr_src[i] != 0);
        check("frc_last", cap_last[i], fr_last[i] != 0);
        check("frc_data", cap_data[i], fr_data[i]);
      end
    end

    // Consumer stalls for 5 cycles in the middle of a burst.
    apply_reset();
    start_capture();
    fork
      send_burst(0, 32'hE0, 6);
      begin
        idle_cycles(4);
        out_ready = 1'b0;
        idle_cycles(5);
        out_ready = 1'b1;
      end
    join
    idle_cycles(3);
    cap_en = 1'b0;
    check("stall_count", cap_data.size(), 6);
    if (cap_data.size() == 6) begin
      for (int i = 0; i < 6; i++) check("stall_data", cap_data[i], 32'hE0 + i);
    end

    // Reset on the second word of a burst, then priority restarts at A.
    apply_reset();
    send_word(0, 32'h51, 1'b0);
    send_word(0, 32'h52, 1'b0);
    check("mid_word", {out_valid, out_data}, {1'b1, 32'h52});
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_busy", busy, 0);
    idle_cycles(1);
    reset = 1'b0;
    start_capture();
    fork
      send_word(0, 32'h61, 1'b1);
      send_word(1, 32'h71, 1'b1);
    join
    idle_cycles(3);
    cap_en = 1'b0;
    check("post_rst_count", cap_data.size(), 2);
    if (cap_data.size() == 2) check("post_rst_first", {cap_src[0], cap_data[0]}, {1'b0, 32'h61});

    // Random traffic, stalls, dropped valids and occasional resets.
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      rd[r] = $urandom;
      rl[r] = ($urandom_range(0, 3) == 0);
    end
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      for (int r = 0; r < 2; r++) begin
        if (acc[r]) begin
          rd[r] = $urandom;
          rl[r] = ($urandom_range(0, 3) == 0);
        end
        drive_req(r, $urandom_range(0, 4) != 0, rd[r], rl[r]);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 499) == 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_req(0, 1'b0, '0, 1'b0);
    drive_req(1, 1'b0, '0, 1'b0);
    out_ready = 1'b1;
    idle_cycles(5);
    check("drain_a", sb_a.size(), 0);
    check("drain_b", sb_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
